motor_dir_sequencer: RTL and testbench

- Downstream stage between the PWM duty generator and the H-bridge driver pins (ENA, IN1/IN2).
- Takes the raw PWM stream and the requested motor direction from slide switches.
- Applies direction changes only through a safe sequence: short-brake, dead-time, re-enable. This prevents shoot-through and reverse-plugging the motor.
- Also exports the applied direction and a busy flag for the FND display.

---
 rtl/motor_dir_sequencer.sv | 122 ++++++++++++
 tb/tb_motor_dir_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/motor_dir_sequencer.sv
// H-bridge direction sequencer: forces brake -> dead-time -> re-enable on any
// direction change so the bridge never shoots through or reverse-plugs the motor.
module motor_dir_sequencer #(
  parameter int unsigned BRAKE_CYCLES = 10_000_000,
  parameter int unsigned DEAD_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  input  logic [1:0] dir_req,
  output logic       pwm_en_out,
  output logic [1:0] in1_in2,
  output logic [1:0] dir_applied,
  output logic       busy
);

  localparam int unsigned MAX_CYCLES = (BRAKE_CYCLES > DEAD_CYCLES) ? BRAKE_CYCLES : DEAD_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] BRAKE_LOAD = CNT_W'(BRAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BRAKE = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [1:0]       cur_dir, cur_dir_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       sync1, req_s;

  // Two-flop synchronizer for the switch inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 2'b00;
      req_s <= 2'b00;
    end else begin
      sync1 <= dir_req;
      req_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cur_dir <= 2'b00;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      cur_dir <= cur_dir_n;
      cnt     <= cnt_n;
    end
  end

  // Next state: requests are only honoured in IDLE and RUN; BRAKE/DEAD run to completion
  always_comb begin
    state_n   = state;
    cur_dir_n = cur_dir;
    cnt_n     = cnt;
    case (state)
      S_IDLE: begin
        if (req_s == 2'b01 || req_s == 2'b10) begin
          state_n   = S_RUN;
          cur_dir_n = req_s;
        end
      end
      S_RUN: begin
        if (req_s != cur_dir) begin
          if (req_s == 2'b00) begin
            state_n = S_DEAD;
            cnt_n   = DEAD_LOAD;
          end else begin
            state_n = S_BRAKE;
            cnt_n   = BRAKE_LOAD;
          end
        end
      end
      S_BRAKE: begin
        if (cnt == '0) begin
          state_n = S_DEAD;
          cnt_n   = DEAD_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_DEAD: begin
        if (cnt == '0) begin
          state_n   = S_IDLE;
          cur_dir_n = 2'b00;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pin decode straight from the state register so reset reaches the pins without a clock
  always_comb begin
    in1_in2     = 2'b00;
    pwm_en_out  = 1'b0;
    dir_applied = 2'b00;
    busy        = 1'b0;
    case (state)
      S_RUN: begin
        in1_in2     = cur_dir;
        pwm_en_out  = pwm_in;
        dir_applied = cur_dir;
      end
      S_BRAKE: begin
        in1_in2    = 2'b11;
        pwm_en_out = 1'b1;
        busy       = 1'b1;
      end
      S_DEAD:  busy = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// Randomized scoreboard bench for motor_dir_sequencer with a phase-plan reference model.
module tb_motor_dir_sequencer;

  localparam int unsigned B = 4;
  localparam int unsigned D = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic [1:0] dir_req;
  logic       pwm_en_out;
  logic [1:0] in1_in2;
  logic [1:0] dir_applied;
  logic       busy;

  motor_dir_sequencer #(.BRAKE_CYCLES(B), .DEAD_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .dir_req     (dir_req),
    .pwm_en_out  (pwm_en_out),
    .in1_in2     (in1_in2),
    .dir_applied (dir_applied),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pins;
    logic       en;
    logic       follow;
    logic [1:0] app;
    logic       busy;
  } exp_t;

  exp_t       sb[$];
  exp_t       plan[$];
  logic [1:0] dly[$];
  logic [1:0] run_dir;
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         rnd_pwm = 1'b0;

  function automatic exp_t mk(logic [1:0] p, logic e, logic f, logic [1:0] a, logic b);
    exp_t r;
    r.pins = p; r.en = e; r.follow = f; r.app = a; r.busy = b;
    return r;
  endfunction

  // Model: direction changes expand into a fixed plan of output phases
  task automatic model_step();
    exp_t       o;
    logic [1:0] req;
    if (!reset) begin
      plan.delete();
      dly = '{2'b00, 2'b00};
      run_dir = 2'b00;
      sb.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b0));
      return;
    end
    req = dly.pop_front();
    dly.push_back(dir_req);
    if (plan.size() > 0) begin
      o = plan.pop_front();
    end else if (run_dir == 2'b00) begin
      if (req == 2'b01 || req == 2'b10) begin
        run_dir = req;
        o = mk(req, 1'b0, 1'b1, req, 1'b0);
      end else begin
        o = mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      end
    end else if (req == run_dir) begin
      o = mk(run_dir, 1'b0, 1'b1, run_dir, 1'b0);
    end else begin
      if (req != 2'b00) begin
        o = mk(2'b11, 1'b1, 1'b0, 2'b00, 1'b1);
        for (int i = 1; i < int'(B); i++) plan.push_back(mk(2'b11, 1'b1, 1'b0, 2'b00, 1'b1));
        for (int i = 0; i < int'(D); i++) plan.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b1));
      end else begin
        o = mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
        for (int i = 1; i < int'(D); i++) plan.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b1));
      end
      plan.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b0));
      run_dir = 2'b00;
    end
    sb.push_back(o);
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      pwm_in = rnd_pwm ? 1'($urandom_range(0, 1)) : ~pwm_in;
    end
  endtask

  task automatic check_reset_outputs();
    n_tests++;
    if ({in1_in2, pwm_en_out, dir_applied, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_immediate t=%0t got pins=%b en=%b app=%b busy=%b, required all zero",
               $time, in1_in2, pwm_en_out, dir_applied, busy);
    end
  endtask

  // Mid-cycle asynchronous reset: the pending expectation is discarded
  task automatic async_reset(input int hold);
    reset = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs();
    cycle(hold);
    reset = 1'b1;
  endtask

  // Monitor: compares every cycle and enforces the pin-transition safety rules
  logic [1:0] prev_pins = 2'b00;
  initial begin
    exp_t e;
    logic exp_en;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        exp_en = e.follow ? pwm_in : e.en;
        n_tests++;
        if ({in1_in2, pwm_en_out, dir_applied, busy} !== {e.pins, exp_en, e.app, e.busy}) begin
          n_fail++;
          $display("FAIL outputs t=%0t got pins=%b en=%b app=%b busy=%b, required pins=%b en=%b app=%b busy=%b",
                   $time, in1_in2, pwm_en_out, dir_applied, busy, e.pins, exp_en, e.app, e.busy);
        end
      end
      n_tests++;
      if ((prev_pins == 2'b11 && (in1_in2 == 2'b01 || in1_in2 == 2'b10)) ||
          (prev_pins == 2'b01 && in1_in2 == 2'b10) || (prev_pins == 2'b10 && in1_in2 == 2'b01)) begin
        n_fail++;
        $display("FAIL pin_sequence t=%0t got %b -> %b, required a brake/off phase between",
                 $time, prev_pins, in1_in2);
      end
      prev_pins = in1_in2;
    end
  end

  initial begin
    reset   = 1'b0;
    pwm_in  = 1'b0;
    dir_req = 2'b01;
    #1;
    check_reset_outputs();
    cycle(3);
    reset = 1'b1;
    cycle(8);
    // forward -> reverse through brake and dead time
    dir_req = 2'b10; cycle(16);
    // reverse -> stop coasts without braking
    dir_req = 2'b00; cycle(10);
    // requests toggled during brake are ignored; last value wins in IDLE
    dir_req = 2'b01; cycle(6);
    dir_req = 2'b10; cycle(4);
    dir_req = 2'b01; cycle(2);
    dir_req = 2'b10; cycle(1);
    dir_req = 2'b01; cycle(12);
    dir_req = 2'b10; cycle(4);
    dir_req = 2'b01; cycle(2);
    dir_req = 2'b11; cycle(15);
    // reset on the second brake clock
    dir_req = 2'b01; cycle(6);
    dir_req = 2'b10; cycle(4);
    dir_req = 2'b01;
    async_reset(2);
    cycle(8);
    // idle holds with brake/stop requests
    dir_req = 2'b00; cycle(10);
    dir_req = 2'b11; cycle(20);
    dir_req = 2'b00; cycle(20);
    // randomized phase
    rnd_pwm = 1'b1;
    for (int k = 0; k < 120; k++) begin
      dir_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) async_reset(int'($urandom_range(1, 3)));
      cycle(int'($urandom_range(1, 14)));
    end
    cycle(12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
